key_level_ctrl: RTL and testbench
=================================

Name: key_level_ctrl

Overview:
Key-driven control stage directly upstream of the brightness/colour adjust stage. Synchronises and debounces four raw push-buttons and runs a channel-select state machine. Holds four 3-bit adjustment levels (global RGB, R, G, B) and publishes them to the adjust stage. Published values change only at a frame boundary, so a frame never carries mixed settings.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms at 50 MHz)
LEVEL_MAX, 7, saturation ceiling for every level (must be ≤ 7)
VS_POL, 1, active polarity of vs_in (1 = active-high sync pulse)

Ports:
clk  input  1  pixel/system clock, single clock domain
rst  input  1  synchronous, active-high reset
key_sel_n  input  1  raw select button, active-low, asynchronous to clk
key_up_n  input  1  raw increment button, active-low, asynchronous
key_down_n  input  1  raw decrement button, active-low, asynchronous
key_clr_n  input  1  raw clear-all button, active-low, asynchronous
vs_in  input  1  vertical sync of the video stream entering the adjust stage
rgb_ctrl_plus10  output  3  published global level
r_ctrl_plus10  output  3  published red level
g_ctrl_plus10  output  3  published green level
b_ctrl_plus10  output  3  published blue level
sel_led  output  4  one-hot current selection: bit0 RGB, bit1 R, bit2 G, bit3 B

Behaviour:
- Reset (rst high at a clk edge): all working and published levels 0; selection SEL_RGB; sel_led = 4'b0001; synchronisers and debounced states = 1 (released); debounce counters 0; vs edge register = inactive level.
- Input path per key: 2-FF synchroniser, then debounce filter.
  - Debounce counter clears whenever the synchronised value equals the debounced state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronised value and the counter clears.
  - Counter width = clog2(DEBOUNCE_CYCLES).
- Press event: one-cycle pulse when a debounced state goes 1→0. Release generates nothing. Holding a key produces exactly one event (no auto-repeat).
- Select FSM with states SEL_RGB → SEL_R → SEL_G → SEL_B → SEL_RGB:
  - Advances one state per sel event and wraps after SEL_B.
  - sel_led is registered and one-hot, updated in the same cycle as the state.
- Working levels, update rules in priority order (same edge as the event, evaluated on the pre-update selection):
  1. clr event: all four working levels → 0. Coincident up/down events are ignored.
  2. up and down events in the same cycle: no change.
  3. up event: selected level +1, saturating at LEVEL_MAX.
  4. down event: selected level −1, saturating at 0.
- sel coincident with up/down: the level change applies to the old selection; the selection then advances.
- Frame-boundary publish:
  - vs_in is registered once. Active edge = transition into the VS_POL level.
  - On the cycle the edge is detected, all four outputs load the working levels atomically (latency: edge on vs_in → outputs updated 2 clk edges later).
  - With no vs edge, outputs hold indefinitely, even if the working levels change.
  - A key event landing on the same cycle as the publish load is not published; it is published at the next frame.
- Mid-operation reset: a pending debounce count or press in progress is discarded. A key still held after reset release produces no event until it is released and pressed again.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=16, LEVEL_MAX=7, VS_POL=1.)
1. Debounce: key_up_n low for 10 cycles then high, plus bounce toggles every 3 cycles for 40 cycles → no level change. Clean 30-cycle press → rgb level 0→1 after the next vs rising edge; exactly one increment.
2. Saturation: 9 up presses on SEL_RGB, then vs edge → rgb_ctrl_plus10=7. 9 down presses, then vs edge → 0, never wrapping below 0.
3. Select wrap: 4 sel presses → sel_led 0010, 0100, 1000, 0001. Select R, 3 ups, vs → r_ctrl_plus10=3 and others 0.
4. Frame gating: 2 ups with vs_in held low → outputs stay 0. Single vs 0→1 pulse → output = 2 exactly 2 clk edges after vs rises.
5. Simultaneous events: up+down debounced on the same cycle → no change. sel+up on the same cycle on SEL_RGB → rgb +1, selection becomes SEL_R. clr+up → all 0.
6. Reset mid-press: rst asserted at counter=8 while key held, released while still held → no event. Release, then fresh press → one event. Outputs 0 and sel_led 0001 throughout reset.

Source files
------------

// File: rtl/key_level_ctrl.sv
// Key-driven level control: synchronises and debounces four push-buttons,
// cycles a channel selection, and keeps four saturating 3-bit levels that
// are published to the adjust stage only at a vertical-sync edge.
module key_level_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LEVEL_MAX       = 7,
  parameter bit          VS_POL          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_sel_n,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       key_clr_n,
  input  logic       vs_in,
  output logic [2:0] rgb_ctrl_plus10,
  output logic [2:0] r_ctrl_plus10,
  output logic [2:0] g_ctrl_plus10,
  output logic [2:0] b_ctrl_plus10,
  output logic [3:0] sel_led
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LvlMax = 3'(LEVEL_MAX);

  // Key index: 0 sel, 1 up, 2 down, 3 clr
  typedef enum logic [1:0] {SelRgb, SelR, SelG, SelB} sel_e;

  logic [3:0]      w_keys_n;
  logic [3:0]      r_sync1, r_sync2, r_db, r_db_prev, r_armed;
  logic [3:0]      w_db_next, w_armed_next, w_evt;
  logic [CntW-1:0] r_cnt [4];
  logic [CntW-1:0] w_cnt_next [4];
  sel_e            r_sel, w_sel_next;
  logic [3:0]      r_sel_led, w_led_next;
  logic [1:0]      w_idx;
  logic [2:0]      r_lvl [4];
  logic [2:0]      w_lvl_next [4];
  logic [2:0]      r_pub [4];
  logic            r_vs_q, r_vs_d, w_vs_edge;

  assign w_keys_n = {key_clr_n, key_down_n, key_up_n, key_sel_n};

  // Debounce next state. A key is unarmed after reset until it has been seen
  // released for a full debounce window, so a key held through reset cannot
  // produce a press on reset release.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_cnt_next[k]   = r_cnt[k];
      w_db_next[k]    = r_db[k];
      w_armed_next[k] = r_armed[k];
      if (!r_armed[k]) begin
        if (!r_sync2[k]) begin
          w_cnt_next[k] = '0;
        end else if (r_cnt[k] == CntLast) begin
          w_cnt_next[k]   = '0;
          w_armed_next[k] = 1'b1;
        end else begin
          w_cnt_next[k] = r_cnt[k] + CntW'(1);
        end
      end else if (r_sync2[k] == r_db[k]) begin
        w_cnt_next[k] = '0;
      end else if (r_cnt[k] == CntLast) begin
        w_cnt_next[k] = '0;
        w_db_next[k]  = r_sync2[k];
      end else begin
        w_cnt_next[k] = r_cnt[k] + CntW'(1);
      end
    end
  end

  // Press pulse on a debounced 1->0 transition of an armed key
  assign w_evt = r_armed & r_db_prev & ~r_db;

  // Synchroniser and debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 4'hf;
      r_sync2   <= 4'hf;
      r_db      <= 4'hf;
      r_db_prev <= 4'hf;
      r_armed   <= 4'h0;
      for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
    end else begin
      r_sync1   <= w_keys_n;
      r_sync2   <= r_sync1;
      r_db      <= w_db_next;
      r_db_prev <= r_db;
      r_armed   <= w_armed_next;
      for (int k = 0; k < 4; k++) r_cnt[k] <= w_cnt_next[k];
    end
  end

  // Selection FSM next state and one-hot LED pattern
  always_comb begin
    w_sel_next = r_sel;
    if (w_evt[0]) begin
      unique case (r_sel)
        SelRgb:  w_sel_next = SelR;
        SelR:    w_sel_next = SelG;
        SelG:    w_sel_next = SelB;
        default: w_sel_next = SelRgb;
      endcase
    end
    unique case (w_sel_next)
      SelRgb:  w_led_next = 4'b0001;
      SelR:    w_led_next = 4'b0010;
      SelG:    w_led_next = 4'b0100;
      default: w_led_next = 4'b1000;
    endcase
  end

  // Selection state and LED registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel     <= SelRgb;
      r_sel_led <= 4'b0001;
    end else begin
      r_sel     <= w_sel_next;
      r_sel_led <= w_led_next;
    end
  end

  assign w_idx = r_sel;

  // Working level update on the pre-advance selection; clr dominates
  always_comb begin
    for (int k = 0; k < 4; k++) w_lvl_next[k] = r_lvl[k];
    if (w_evt[3]) begin
      for (int k = 0; k < 4; k++) w_lvl_next[k] = 3'd0;
    end else if (w_evt[1] && !w_evt[2]) begin
      if (r_lvl[w_idx] < LvlMax) w_lvl_next[w_idx] = r_lvl[w_idx] + 3'd1;
    end else if (w_evt[2] && !w_evt[1]) begin
      if (r_lvl[w_idx] != 3'd0) w_lvl_next[w_idx] = r_lvl[w_idx] - 3'd1;
    end
  end

  // Active vs edge seen one cycle after vs_in is registered
  assign w_vs_edge = (r_vs_q == VS_POL) && (r_vs_d != VS_POL);

  // Working levels, vs edge history and atomic frame-boundary publish
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vs_q <= ~VS_POL;
      r_vs_d <= ~VS_POL;
      for (int k = 0; k < 4; k++) begin
        r_lvl[k] <= 3'd0;
        r_pub[k] <= 3'd0;
      end
    end else begin
      r_vs_q <= vs_in;
      r_vs_d <= r_vs_q;
      for (int k = 0; k < 4; k++) begin
        r_lvl[k] <= w_lvl_next[k];
        if (w_vs_edge) r_pub[k] <= r_lvl[k];
      end
    end
  end

  assign rgb_ctrl_plus10 = r_pub[0];
  assign r_ctrl_plus10   = r_pub[1];
  assign g_ctrl_plus10   = r_pub[2];
  assign b_ctrl_plus10   = r_pub[3];
  assign sel_led         = r_sel_led;

endmodule

// File: tb/tb_key_level_ctrl.sv
// Scoreboard bench for key_level_ctrl with a short debounce window.
module tb_key_level_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_sel_n, key_up_n, key_down_n, key_clr_n, vs_in;
  logic [2:0] rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10;
  logic [3:0] sel_led;

  always #5 clk = ~clk;

  key_level_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .LEVEL_MAX      (7),
    .VS_POL         (1'b1)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .key_sel_n      (key_sel_n),
    .key_up_n       (key_up_n),
    .key_down_n     (key_down_n),
    .key_clr_n      (key_clr_n),
    .vs_in          (vs_in),
    .rgb_ctrl_plus10(rgb_ctrl_plus10),
    .r_ctrl_plus10  (r_ctrl_plus10),
    .g_ctrl_plus10  (g_ctrl_plus10),
    .b_ctrl_plus10  (b_ctrl_plus10),
    .sel_led        (sel_led)
  );

  typedef struct {
    logic [11:0] lvl;
    logic [3:0]  led;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [2:0] m_lvl [4];
  logic [2:0] m_pub [4];
  int         m_sel;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.lvl = {m_pub[0], m_pub[1], m_pub[2], m_pub[3]};
    e.led = 4'(1 << m_sel);
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    check_val({tag, "_queued"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({tag, "_levels"},
                {20'd0, rgb_ctrl_plus10, r_ctrl_plus10, g_ctrl_plus10, b_ctrl_plus10}, {20'd0, e.lvl});
      check_val({tag, "_sel_led"}, {28'd0, sel_led}, {28'd0, e.led});
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_lvl[k] = 3'd0;
      m_pub[k] = 3'd0;
    end
    m_sel = 0;
  endtask

  task automatic model_evt(input bit s, input bit u, input bit d, input bit c);
    if (c) begin
      for (int k = 0; k < 4; k++) m_lvl[k] = 3'd0;
    end else if (u && !d) begin
      if (m_lvl[m_sel] < 3'd7) m_lvl[m_sel] = m_lvl[m_sel] + 3'd1;
    end else if (d && !u) begin
      if (m_lvl[m_sel] > 3'd0) m_lvl[m_sel] = m_lvl[m_sel] - 3'd1;
    end
    if (s) m_sel = (m_sel + 1) % 4;
  endtask

  // Clean press of the chosen keys together, then a clean release
  task automatic press(input bit s, input bit u, input bit d, input bit c);
    @(negedge clk);
    key_sel_n  = ~s;
    key_up_n   = ~u;
    key_down_n = ~d;
    key_clr_n  = ~c;
    repeat (30) @(negedge clk);
    {key_sel_n, key_up_n, key_down_n, key_clr_n} = 4'hf;
    repeat (30) @(negedge clk);
    model_evt(s, u, d, c);
  endtask

  // vs rising edge: outputs must still be old after one edge, new after two
  task automatic vs_pulse(input string tag);
    @(negedge clk);
    vs_in = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    sb_check({tag, "_edge1"});
    for (int k = 0; k < 4; k++) m_pub[k] = m_lvl[k];
    push_exp();
    @(posedge clk);
    #1;
    sb_check({tag, "_edge2"});
    @(negedge clk);
    vs_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    {key_sel_n, key_up_n, key_down_n, key_clr_n} = 4'hf;
    vs_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_exp();
    sb_check("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    // Debounce: short press and bouncing must not register
    key_up_n = 1'b0;
    repeat (10) @(negedge clk);
    key_up_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) key_up_n = ~key_up_n;
      @(negedge clk);
    end
    key_up_n = 1'b1;
    repeat (30) @(negedge clk);
    vs_pulse("bounce");
    press(0, 1, 0, 0);
    vs_pulse("clean_up");

    // Saturation both ways
    for (int i = 0; i < 9; i++) press(0, 1, 0, 0);
    vs_pulse("sat_hi");
    for (int i = 0; i < 9; i++) press(0, 0, 1, 0);
    vs_pulse("sat_lo");

    // Select wrap with LED checks
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 0, 0);
      push_exp();
      sb_check("sel_wrap");
    end
    press(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0);
    vs_pulse("red3");

    // Back to RGB, then frame gating: no publish without vs edge
    for (int i = 0; i < 3; i++) press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    repeat (20) @(negedge clk);
    push_exp();
    sb_check("gated");
    vs_pulse("gate_pub");

    // Simultaneous events
    press(0, 1, 1, 0);
    vs_pulse("up_down");
    press(1, 1, 0, 0);
    push_exp();
    sb_check("sel_up_led");
    vs_pulse("sel_up");
    press(0, 1, 0, 1);
    vs_pulse("clr_up");

    // Reset while a press is being debounced
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    vs_pulse("pre_rst");
    @(negedge clk);
    key_up_n = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      push_exp();
      @(posedge clk);
      #1;
      sb_check("in_reset");
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    push_exp();
    sb_check("held_after_rst");
    key_up_n = 1'b1;
    repeat (30) @(negedge clk);
    vs_pulse("rst_no_evt");
    press(0, 1, 0, 0);
    vs_pulse("rst_fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
